// File: rtl/lzw_cam_pkg.sv
// Shared types for the LZW dictionary CAM: FSM states, stored key layout and count width helper.
// Key fields are sized for the widest supported configuration; narrower builds zero-extend.
package lzw_cam_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      RESP    = 2'd2,
      CLEAR   = 2'd3
   } cam_state_t;

   localparam int KEY_MAX_CODE_W = 16;
   localparam int KEY_MAX_DATA_W = 16;

   typedef struct packed {
      logic [KEY_MAX_CODE_W-1:0] prefix;
      logic [KEY_MAX_DATA_W-1:0] sym;
   } cam_key_t;

   function automatic int count_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/lzw_dict_cam_if.sv
// Request/response bus between the LZW encoder control and the dictionary CAM.
// Both channels transfer on a cycle where valid && ready; the source holds its fields stable until then.
interface lzw_dict_cam_if #(
   parameter int DATA_W = 8,
   parameter int CODE_W = 12
);
   logic              req_valid;
   logic              req_ready;
   logic [CODE_W-1:0] req_prefix;
   logic [DATA_W-1:0] req_sym;
   logic              req_insert;
   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_hit;
   logic [CODE_W-1:0] rsp_code;
   logic              rsp_inserted;
   logic              rsp_dict_reset;

   modport master (
      output req_valid, req_prefix, req_sym, req_insert, rsp_ready,
      input  req_ready, rsp_valid, rsp_hit, rsp_code, rsp_inserted, rsp_dict_reset
   );

   modport slave (
      input  req_valid, req_prefix, req_sym, req_insert, rsp_ready,
      output req_ready, rsp_valid, rsp_hit, rsp_code, rsp_inserted, rsp_dict_reset
   );
endinterface

// File: rtl/lzw_cam_entry.sv
// One CAM cell: stored key plus valid bit, with a combinational match against the search key.
// Clearing drops only the valid bit; the key bits are left as they were.
module lzw_cam_entry
   import lzw_cam_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     we,
   input  logic     clr,
   input  cam_key_t key,
   output logic     match
);

   logic     valid;
   cam_key_t stored;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
      end else if (clr) begin
         valid <= 1'b0;
      end else if (we) begin
         valid <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         stored <= key;
      end
   end

   assign match = valid && (stored == key);

endmodule

// File: rtl/lzw_dict_cam.sv
// LZW dictionary CAM: handshaked lookup / insert-on-miss engine with fill tracking and clear.
// Optional LZW_DICT_AUTO_CLEAR_EN: the insert that fills the dictionary flags rsp_dict_reset and clears it after the response.
module lzw_dict_cam
   import lzw_cam_pkg::*;
#(
   parameter int  DATA_W    = 8,
   parameter int  CODE_W    = 12,
   parameter int  NUM_ENTRY = 64,
   parameter int  BASE_CODE = 256,
   localparam int CNT_W     = count_width(NUM_ENTRY)
) (
   input  logic                 clk,
   input  logic                 rst,
   lzw_dict_cam_if.slave        bus,
   input  logic                 clear,
   output logic                 full,
   output logic [CNT_W-1:0]     count,
   output cam_state_t           dbg_state
);

   localparam int IDX_W = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1;

   if (BASE_CODE + NUM_ENTRY > (1 << CODE_W)) begin : g_code_range_check
      $error("lzw_dict_cam: BASE_CODE + NUM_ENTRY exceeds the code space");
   end
   if (CODE_W > KEY_MAX_CODE_W || DATA_W > KEY_MAX_DATA_W) begin : g_key_width_check
      $error("lzw_dict_cam: key wider than cam_key_t");
   end

   cam_state_t           state;
   cam_state_t           state_nxt;
   cam_key_t             key_q;
   logic                 ins_q;
   logic                 clear_pend;
   logic [NUM_ENTRY-1:0] match;
   logic                 any_hit;
   logic [IDX_W-1:0]     hit_idx;
   logic                 accept;
   logic                 do_ins;
   logic                 clr_all;
   logic [CNT_W-1:0]     count_inc;
   logic                 rsp_hit_q;
   logic [CODE_W-1:0]    rsp_code_q;
   logic                 rsp_inserted_q;
   logic                 dict_reset_q;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; a clear (live or pending) always wins over a new request
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (clear || clear_pend) begin
               state_nxt = CLEAR;
            end else if (bus.req_valid) begin
               state_nxt = COMPARE;
            end
         end
         COMPARE: state_nxt = RESP;
         RESP: begin
            if (bus.rsp_ready) begin
               state_nxt = (clear_pend || clear || dict_reset_q) ? CLEAR : IDLE;
            end
         end
         CLEAR:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output / control decode
   always_comb begin
      bus.req_ready = (state == IDLE) && !clear_pend && !clear;
      bus.rsp_valid = (state == RESP);
      accept        = bus.req_ready && bus.req_valid;
      do_ins        = (state == COMPARE) && !any_hit && ins_q && !full;
      clr_all       = (state == CLEAR);
   end

   assign dbg_state          = state;
   assign bus.rsp_hit        = rsp_hit_q;
   assign bus.rsp_code       = rsp_code_q;
   assign bus.rsp_inserted   = rsp_inserted_q;
   assign bus.rsp_dict_reset = dict_reset_q;
   assign count_inc          = count + CNT_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_q <= '0;
         ins_q <= 1'b0;
      end else if (accept) begin
         key_q <= '{prefix: KEY_MAX_CODE_W'(bus.req_prefix), sym: KEY_MAX_DATA_W'(bus.req_sym)};
         ins_q <= bus.req_insert;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clear_pend <= 1'b0;
      end else if (clr_all) begin
         clear_pend <= 1'b0;
      end else if (clear && state != IDLE) begin
         clear_pend <= 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_ENTRY; i++) begin : g_cell
      lzw_cam_entry u_cell (
         .clk   (clk),
         .rst   (rst),
         .we    (do_ins && (count == CNT_W'(i))),
         .clr   (clr_all),
         .key   (key_q),
         .match (match[i])
      );
   end

   // Lowest matching index wins should duplicates ever be present
   always_comb begin
      any_hit = 1'b0;
      hit_idx = '0;
      for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
         if (match[i]) begin
            any_hit = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         full  <= 1'b0;
      end else if (clr_all) begin
         count <= '0;
         full  <= 1'b0;
      end else if (do_ins) begin
         count <= count_inc;
         full  <= (count_inc == CNT_W'(NUM_ENTRY));
      end
   end

   // Response fields are captured once at the end of COMPARE and held through RESP
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_hit_q      <= 1'b0;
         rsp_code_q     <= '0;
         rsp_inserted_q <= 1'b0;
      end else if (state == COMPARE) begin
         rsp_hit_q      <= any_hit;
         rsp_inserted_q <= do_ins;
         if (any_hit) begin
            rsp_code_q <= CODE_W'(BASE_CODE) + CODE_W'(hit_idx);
         end else if (do_ins) begin
            rsp_code_q <= CODE_W'(BASE_CODE) + CODE_W'(count);
         end else begin
            rsp_code_q <= '0;
         end
      end
   end

`ifdef LZW_DICT_AUTO_CLEAR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dict_reset_q <= 1'b0;
      end else if (state == COMPARE) begin
         dict_reset_q <= do_ins && (count_inc == CNT_W'(NUM_ENTRY));
      end
   end
`else
   assign dict_reset_q = 1'b0;
`endif

endmodule

// File: tb/tb_lzw_dict_cam.sv
// Directed bench for lzw_dict_cam: vector table for lookup/insert, plus stall, clear, reset and fill sequences.
module tb_lzw_dict_cam;
   import lzw_cam_pkg::*;

   localparam int DATA_W    = 8;
   localparam int CODE_W    = 12;
   localparam int NUM_ENTRY = 64;
   localparam int BASE_CODE = 256;
   localparam int CNT_W     = $clog2(NUM_ENTRY + 1);
   localparam int NV        = 10;

   typedef struct {
      logic [CODE_W-1:0] prefix;
      logic [DATA_W-1:0] sym;
      logic              ins;
      logic              hit;
      logic [CODE_W-1:0] code;
      logic              inserted;
      int                cnt;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             clear;
   logic             full;
   logic [CNT_W-1:0] count;
   cam_state_t       dbg_state;

   int total = 0;
   int bad   = 0;
   logic [CODE_W-1:0] exp_q[$];
   vec_t v[NV];

   lzw_dict_cam_if #(.DATA_W(DATA_W), .CODE_W(CODE_W)) bus ();

   lzw_dict_cam #(
      .DATA_W(DATA_W), .CODE_W(CODE_W), .NUM_ENTRY(NUM_ENTRY), .BASE_CODE(BASE_CODE)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .clear(clear),
      .full(full), .count(count), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // Present a request at a negedge; return at the negedge after it was accepted (DUT in COMPARE)
   task automatic start(input logic [CODE_W-1:0] p, input logic [DATA_W-1:0] s, input logic ins);
      int n = 0;
      bus.req_prefix = p;
      bus.req_sym    = s;
      bus.req_insert = ins;
      bus.req_valid  = 1'b1;
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got no req_ready in %0d cycles want ready", n);
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic finish(output logic hit, output logic [CODE_W-1:0] code, output logic inserted,
                         output logic dr, output int lat);
      lat = 1;
      while (!bus.rsp_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      hit      = bus.rsp_hit;
      code     = bus.rsp_code;
      inserted = bus.rsp_inserted;
      dr       = bus.rsp_dict_reset;
   endtask

   task automatic txn(input logic [CODE_W-1:0] p, input logic [DATA_W-1:0] s, input logic ins,
                      output logic hit, output logic [CODE_W-1:0] code, output logic inserted,
                      output logic dr, output int lat);
      start(p, s, ins);
      finish(hit, code, inserted, dr, lat);
      @(negedge clk);
   endtask

   initial begin
      logic              hit;
      logic [CODE_W-1:0] code;
      logic              inserted;
      logic              dr;
      int                lat;

      v[0] = '{12'h041, 8'h42, 1'b0, 1'b0, 12'd0,   1'b0, 0};
      v[1] = '{12'h041, 8'h42, 1'b1, 1'b0, 12'd256, 1'b1, 1};
      v[2] = '{12'h041, 8'h42, 1'b0, 1'b1, 12'd256, 1'b0, 1};
      v[3] = '{12'h041, 8'h42, 1'b1, 1'b1, 12'd256, 1'b0, 1};
      v[4] = '{12'h100, 8'h00, 1'b1, 1'b0, 12'd257, 1'b1, 2};
      v[5] = '{12'h041, 8'h43, 1'b0, 1'b0, 12'd0,   1'b0, 2};
      v[6] = '{12'h042, 8'h42, 1'b0, 1'b0, 12'd0,   1'b0, 2};
      v[7] = '{12'h100, 8'h00, 1'b0, 1'b1, 12'd257, 1'b0, 2};
      v[8] = '{12'hFFF, 8'hFF, 1'b1, 1'b0, 12'd258, 1'b1, 3};
      v[9] = '{12'hFFF, 8'hFF, 1'b0, 1'b1, 12'd258, 1'b0, 3};

      // clock / reset
      rst = 1'b1;
      clear = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_prefix = '0;
      bus.req_sym = '0;
      bus.req_insert = 1'b0;
      bus.rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_req_ready", bus.req_ready, 1);
      check("rst_count", count, 0);
      check("rst_full", full, 0);
      check("rst_hit", bus.rsp_hit, 0);
      check("rst_code", bus.rsp_code, 0);
      check("rst_inserted", bus.rsp_inserted, 0);
      check("rst_dict_reset", bus.rsp_dict_reset, 0);
      check("rst_state", dbg_state, IDLE);

      // vector table
      for (int i = 0; i < NV; i++) begin
         txn(v[i].prefix, v[i].sym, v[i].ins, hit, code, inserted, dr, lat);
         check($sformatf("v%0d_latency", i), lat, 2);
         check($sformatf("v%0d_hit", i), hit, v[i].hit);
         check($sformatf("v%0d_code", i), code, v[i].code);
         check($sformatf("v%0d_inserted", i), inserted, v[i].inserted);
         check($sformatf("v%0d_dict_reset", i), dr, 0);
         check($sformatf("v%0d_count", i), count, v[i].cnt);
      end

      // stalled hit with a clear arriving mid-stall
      bus.rsp_ready = 1'b0;
      start(12'h041, 8'h42, 1'b0);
      finish(hit, code, inserted, dr, lat);
      check("stall_latency", lat, 2);
      for (int k = 0; k < 5; k++) begin
         if (k == 1) clear = 1'b1;
         if (k == 2) clear = 1'b0;
         @(negedge clk);
         check($sformatf("stall%0d_valid", k), bus.rsp_valid, 1);
         check($sformatf("stall%0d_hit", k), bus.rsp_hit, 1);
         check($sformatf("stall%0d_code", k), bus.rsp_code, 256);
         check($sformatf("stall%0d_inserted", k), bus.rsp_inserted, 0);
         check($sformatf("stall%0d_req_ready", k), bus.req_ready, 0);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check("stall_clear_state", dbg_state, CLEAR);
      @(negedge clk);
      check("stall_post_state", dbg_state, IDLE);
      check("stall_post_count", count, 0);
      txn(12'h041, 8'h42, 1'b0, hit, code, inserted, dr, lat);
      check("stall_old_key_hit", hit, 0);
      check("stall_old_key_code", code, 0);

      // clear and request together in IDLE
      txn(12'h0AA, 8'h55, 1'b1, hit, code, inserted, dr, lat);
      check("sim_pre_code", code, 256);
      check("sim_pre_count", count, 1);
      bus.req_prefix = 12'h0BB;
      bus.req_sym = 8'h66;
      bus.req_insert = 1'b1;
      bus.req_valid = 1'b1;
      clear = 1'b1;
      #1;
      check("sim_req_ready", bus.req_ready, 0);
      @(negedge clk);
      clear = 1'b0;
      check("sim_state_clear", dbg_state, CLEAR);
      @(negedge clk);
      check("sim_count", count, 0);
      check("sim_req_ready_after", bus.req_ready, 1);
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("sim_accepted", dbg_state, COMPARE);
      finish(hit, code, inserted, dr, lat);
      @(negedge clk);
      check("sim_latency", lat, 2);
      check("sim_inserted", inserted, 1);
      check("sim_code", code, 256);
      txn(12'h0AA, 8'h55, 1'b0, hit, code, inserted, dr, lat);
      check("sim_old_key_hit", hit, 0);

      // reset while an insert is in COMPARE
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      start(12'h123, 8'h9A, 1'b1);
      check("rstc_in_compare", dbg_state, COMPARE);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rstc_count", count, 0);
      check("rstc_rsp_valid", bus.rsp_valid, 0);
      check("rstc_state", dbg_state, IDLE);
      @(negedge clk);
      check("rstc_count_later", count, 0);
      txn(12'h123, 8'h9A, 1'b0, hit, code, inserted, dr, lat);
      check("rstc_lookup_hit", hit, 0);
      txn(12'h123, 8'h9A, 1'b1, hit, code, inserted, dr, lat);
      check("rstc_insert_code", code, 256);
      check("rstc_insert_latency", lat, 2);

      // fill to capacity
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NUM_ENTRY; i++) exp_q.push_back(CODE_W'(BASE_CODE + i));
      for (int i = 0; i < NUM_ENTRY; i++) begin
         logic [CODE_W-1:0] exp_code;
         logic [CODE_W-1:0] p;
         logic [DATA_W-1:0] s;
         p = CODE_W'(12'h200 + i);
         s = DATA_W'(i);
         txn(p, s, 1'b1, hit, code, inserted, dr, lat);
         exp_code = exp_q.pop_front();
         check($sformatf("fill%0d_code", i), code, exp_code);
         check($sformatf("fill%0d_inserted", i), inserted, 1);
         if (i == NUM_ENTRY - 2) check("fill_full_before_last", full, 0);
`ifdef LZW_DICT_AUTO_CLEAR_EN
         check($sformatf("fill%0d_dict_reset", i), dr, (i == NUM_ENTRY - 1) ? 1 : 0);
`else
         check($sformatf("fill%0d_dict_reset", i), dr, 0);
`endif
      end
`ifdef LZW_DICT_AUTO_CLEAR_EN
      check("auto_clear_state", dbg_state, CLEAR);
      @(negedge clk);
      check("auto_count", count, 0);
      check("auto_full", full, 0);
      txn(12'h200, 8'h00, 1'b0, hit, code, inserted, dr, lat);
      check("auto_old_key_hit", hit, 0);
`else
      check("fill_full", full, 1);
      check("fill_count", count, 64);
      txn(12'h3FF, 8'hEE, 1'b1, hit, code, inserted, dr, lat);
      check("over_hit", hit, 0);
      check("over_inserted", inserted, 0);
      check("over_code", code, 0);
      check("over_count", count, 64);
      check("over_full", full, 1);
      txn(12'h200, 8'h00, 1'b0, hit, code, inserted, dr, lat);
      check("first_key_hit", hit, 1);
      check("first_key_code", code, 256);
      txn(12'h23F, 8'h3F, 1'b1, hit, code, inserted, dr, lat);
      check("last_key_hit", hit, 1);
      check("last_key_code", code, 319);
      check("last_key_inserted", inserted, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/lzw_dict_cam.md
Name: lzw_dict_cam

Overview:
Parametrised LZW dictionary CAM storing (prefix code, symbol) pairs in up to NUM_ENTRY cells with a fully parallel compare. A lookup returns the assigned dictionary code on a hit. On a miss it optionally inserts the pair at the next free cell. Sits between the LZW encoder control FSM and the output packer, replacing the single-width cell array with a handshaked, multi-cycle search/insert engine that tracks fill level and supports dictionary clear.

Parameters:
DATA_W, 8, symbol width in bits
CODE_W, 12, dictionary code width; BASE_CODE+NUM_ENTRY must be <= 2**CODE_W (elaboration assert)
NUM_ENTRY, 64, number of CAM cells
BASE_CODE, 256, code assigned to cell 0 (first code after literals)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&ready
req_prefix  in  CODE_W  prefix code of key
req_sym  in  DATA_W  symbol of key
req_insert  in  1  1 = insert on miss, 0 = lookup only
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_hit  out  1  key found
rsp_code  out  CODE_W  matched or newly assigned code
rsp_inserted  out  1  key written this transaction
rsp_dict_reset  out  1  dictionary auto-cleared after this response (optional feature)
clear  in  1  clear all entries
full  out  1  count == NUM_ENTRY
count  out  $clog2(NUM_ENTRY+1)  number of valid entries

Behaviour:
- Reset: all cell valid bits 0, count=0, full=0, state IDLE, rsp_valid=0, rsp_hit=0, rsp_code=0, rsp_inserted=0, rsp_dict_reset=0, clear pending flag 0. Reset mid-transaction aborts it with no write.
- FSM IDLE -> COMPARE -> RESP -> IDLE, plus CLEAR. req_ready = (state==IDLE) && !clear_pend && !clear.
- IDLE: on req handshake, register key and insert flag; go to COMPARE.
- COMPARE: each cell flags match = valid && stored key == registered key. Register the match vector and the priority-encoded lowest index; go to RESP.
- RESP entry (cycle 2 after accept): rsp_valid=1.
  - Hit: rsp_hit=1, rsp_code=BASE_CODE+index, rsp_inserted=0.
  - Miss, insert, !full: write key to cell[count], set its valid bit; rsp_code=BASE_CODE+old count; rsp_inserted=1; count increments once.
  - Miss, no insert or full: rsp_hit=0, rsp_inserted=0, rsp_code=0, no write.
- RESP hold: response fields stay stable while rsp_valid && !rsp_ready. On handshake, go to IDLE, or to CLEAR if clear_pend is set.
- Latency: accept to rsp_valid is 2 cycles. Throughput is one transaction per 3 cycles at most.
- Clear:
  - clear high in IDLE -> CLEAR. clear takes priority over a simultaneous req_valid (request not accepted).
  - clear high in any other state sets clear_pend.
  - CLEAR lasts 1 cycle: all valid bits 0, count=0, clear_pend=0, then IDLE. Stored key bits are not cleared.
- full is registered and tracks count. An insert reaching NUM_ENTRY raises full on the cycle after the write.
- Duplicate keys cannot arise through this interface. If present, the lowest index wins.

Optional Feature:
Macro LZW_DICT_AUTO_CLEAR_EN.
- Defined: an insert that makes count == NUM_ENTRY sets rsp_dict_reset=1 in that response. After the rsp handshake the FSM enters CLEAR automatically.
- Undefined: rsp_dict_reset is tied 0. The dictionary saturates, and misses with req_insert=1 while full return rsp_inserted=0.

Decomposition:
- Package lzw_cam_pkg: state enum (IDLE, COMPARE, RESP, CLEAR), key struct {prefix, sym}, and a localparam function for count width.
- Sub-module lzw_cam_entry (one cell): holds key and valid, takes write-enable and clear, outputs a combinational match bit. Instantiated NUM_ENTRY times via generate.

Test Plan:
- Reset, then lookup prefix=0x041 sym=0x42 insert=0 -> rsp_valid at cycle 2, hit=0, code=0, count=0.
- Same key with insert=1 -> hit=0, inserted=1, code=256, count=1. Repeat lookup -> hit=1, code=256, inserted=0.
- Fill with 64 distinct keys -> codes 256..319, full=1. 65th miss with insert -> inserted=0, count stays 64 (macro off). With macro: the 64th insert sets rsp_dict_reset=1, then count=0 and full=0 after handshake.
- Hold rsp_ready=0 for 5 cycles on a hit -> rsp fields stable, req_ready=0. Assert clear during the stall -> after handshake, one CLEAR cycle, count=0, and a prior key now misses.
- Simultaneous clear and req_valid in IDLE -> request not accepted, count=0 next cycle, request accepted afterwards.
- Assert rst in COMPARE of an insert -> no write, count=0, rsp_valid=0. The next transaction behaves as after reset.
